// File: rtl/seg_scan_driver.sv
// ============================================================================
// Module   : seg_scan_driver
// Brief    : Time-multiplexed common-anode seven-segment driver. It keeps a
//            double-buffered frame of glyph codes and inserts per-slot
//            anode dead-time. The optional macro LEADING_ZERO_BLANK_EN
//            blanks leading zeros at commit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_start,
    output logic                    pending
);

    localparam int                c_CNT_W    = $clog2(REFRESH_DIV);
    localparam int                c_IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_DEAD     = c_CNT_W'(DEAD_CYCLES);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [3:0]         c_BLANK    = 4'd11;

    logic [c_CNT_W-1:0]              r_cnt;
    logic [c_IDX_W-1:0]              r_idx;
    logic                            r_frame_start;
    logic                            r_pending;
    logic [NUM_DIGITS-1:0][3:0]      r_act_codes;
    logic [NUM_DIGITS-1:0]           r_act_dp;
    logic [NUM_DIGITS-1:0][3:0]      r_pend_codes;
    logic [NUM_DIGITS-1:0]           r_pend_dp;
    logic [6:0]                      r_seg_n;
    logic                            r_dp_n;
    logic [NUM_DIGITS-1:0]           r_an_n;

    logic                            w_tick;
    logic                            w_frame_tick;
    logic [NUM_DIGITS-1:0][3:0]      w_commit_codes;
    logic [NUM_DIGITS-1:0]           w_an_sel;

    function automatic logic [6:0] f_glyph(input logic [3:0] code);
        case (code)
            4'd0:    f_glyph = 7'b0000001;
            4'd1:    f_glyph = 7'b1001111;
            4'd2:    f_glyph = 7'b0010010;
            4'd3:    f_glyph = 7'b0000110;
            4'd4:    f_glyph = 7'b1001100;
            4'd5:    f_glyph = 7'b0100100;
            4'd6:    f_glyph = 7'b0100000;
            4'd7:    f_glyph = 7'b0001111;
            4'd8:    f_glyph = 7'b0000000;
            4'd9:    f_glyph = 7'b0000100;
            4'd10:   f_glyph = 7'b0001000;
            4'd11:   f_glyph = 7'b1111111;
            4'd12:   f_glyph = 7'b0110001;
            4'd13:   f_glyph = 7'b0000001;
            4'd14:   f_glyph = 7'b0110000;
            default: f_glyph = 7'b0111000;
        endcase
    endfunction

    assign w_tick       = (r_cnt == c_CNT_LAST);
    assign w_frame_tick = w_tick && (r_idx == c_IDX_LAST);
    assign w_an_sel     = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx);

    // Leading-zero suppression walks down from the MSD; digit 0 always shows.
    always_comb begin
        w_commit_codes = r_pend_codes;
`ifdef LEADING_ZERO_BLANK_EN
        begin : lzb_walk
            logic w_lead;
            w_lead = 1'b1;
            for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
                if (w_lead && (r_pend_codes[k] == 4'd0)) begin
                    w_commit_codes[k] = c_BLANK;
                end else begin
                    w_lead = 1'b0;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_frame_start <= 1'b0;
            r_pending     <= 1'b0;
            r_act_codes   <= {NUM_DIGITS{c_BLANK}};
            r_act_dp      <= '0;
            r_pend_codes  <= {NUM_DIGITS{c_BLANK}};
            r_pend_dp     <= '0;
            r_seg_n       <= 7'h7F;
            r_dp_n        <= 1'b1;
            r_an_n        <= '1;
        end else begin
            r_cnt         <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end
            r_frame_start <= w_frame_tick;

            // Commit reads the pending buffer as it stood before a coincident load.
            if (w_frame_tick && r_pending) begin
                r_act_codes <= w_commit_codes;
                r_act_dp    <= r_pend_dp;
            end
            if (load) begin
                r_pend_codes <= digits;
                r_pend_dp    <= dp;
            end
            r_pending <= load | (r_pending & ~w_frame_tick);

            if (r_cnt < c_DEAD) begin
                r_seg_n <= 7'h7F;
                r_dp_n  <= 1'b1;
                r_an_n  <= '1;
            end else begin
                r_seg_n <= f_glyph(r_act_codes[r_idx]);
                r_dp_n  <= ~r_act_dp[r_idx];
                r_an_n  <= w_an_sel;
            end
        end
    end

    assign seg_n       = r_seg_n;
    assign dp_n        = r_dp_n;
    assign an_n        = r_an_n;
    assign frame_start = r_frame_start;
    assign pending     = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// ============================================================================
// Module   : tb_seg_scan_driver
// Brief    : Directed self-checking bench for seg_scan_driver (4 digits,
//            4-cycle slots, 1 dead cycle per slot).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int DC = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   digits;
    logic [3:0]    dp;
    logic          load;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic [3:0]    an_n;
    logic          frame_start;
    logic          pending;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] glyph_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1111111,
        7'b0110001, 7'b0000001, 7'b0110000, 7'b0111000
    };

    seg_scan_driver #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .DEAD_CYCLES(DC)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits     (digits),
        .dp         (dp),
        .load       (load),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_start(frame_start),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
        digits = d;
        dp     = p;
        load   = 1'b1;
        step(1);
        load   = 1'b0;
    endtask

    // Frame start cycle F shows the old digit 3; digit k is lit on F+2+4k.
    task automatic capture_frame(output logic [27:0] segs, output logic [3:0] dpn,
                                 output logic [3:0] anok, output logic ok,
                                 output logic pend_fs);
        logic [3:0] m;
        segs = '0; dpn = '0; anok = '0; pend_fs = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (frame_start) break;
            step(1);
        end
        ok      = frame_start;
        pend_fs = pending;
        if (ok) begin
            for (int k = 0; k < 4; k++) begin
                step((k == 0) ? 2 : 4);
                m             = 4'b0001 << k;
                segs[k*7 +: 7] = seg_n;
                dpn[k]        = dp_n;
                anok[k]       = (an_n == ~m);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_tests++;
        if (seg_n !== 7'h7F) begin n_fail++; $display("FAIL %s_seg: got %b want 1111111", tag, seg_n); end
        n_tests++;
        if (an_n !== 4'hF) begin n_fail++; $display("FAIL %s_an: got %b want 1111", tag, an_n); end
        n_tests++;
        if (dp_n !== 1'b1) begin n_fail++; $display("FAIL %s_dp: got %b want 1", tag, dp_n); end
        n_tests++;
        if (pending !== 1'b0) begin n_fail++; $display("FAIL %s_pending: got %b want 0", tag, pending); end
        n_tests++;
        if (frame_start !== 1'b0) begin n_fail++; $display("FAIL %s_fs: got %b want 0", tag, frame_start); end
    endtask

    task automatic check_scan_restart(input string tag);
        int fs_cycle;
        step(1);
        n_tests++;
        if (an_n !== 4'hF) begin n_fail++; $display("FAIL %s_dead: got an_n %b want 1111", tag, an_n); end
        step(1);
        n_tests++;
        if (an_n !== 4'b1110 || seg_n !== 7'h7F) begin
            n_fail++; $display("FAIL %s_slot0: got an_n %b seg %b want 1110 1111111", tag, an_n, seg_n);
        end
        fs_cycle = 0;
        for (int n = 3; n <= 40; n++) begin
            step(1);
            if (frame_start) begin fs_cycle = n; break; end
        end
        n_tests++;
        if (fs_cycle != 16) begin n_fail++; $display("FAIL %s_fs_cycle: got %0d want 16", tag, fs_cycle); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        check_scan_restart("release");
    endtask

    task automatic test_load_midframe();
        logic [27:0] segs; logic [3:0] dpn, anok; logic ok, pf;
        step(3);
        pulse_load(16'h1234, 4'b0000);
        n_tests++;
        if (pending !== 1'b1) begin n_fail++; $display("FAIL mid_pending: got %b want 1", pending); end
        step(2);
        n_tests++;
        if (an_n !== 4'b1101 || seg_n !== 7'h7F) begin
            n_fail++; $display("FAIL mid_no_tear: got an_n %b seg %b want 1101 1111111", an_n, seg_n);
        end
        capture_frame(segs, dpn, anok, ok, pf);
        n_tests++;
        if (!ok || anok !== 4'hF) begin n_fail++; $display("FAIL mid_frame_an: got ok %b anok %b want 1 1111", ok, anok); end
        n_tests++;
        if (segs !== {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}) begin
            n_fail++; $display("FAIL mid_frame_seg: got %h want %h", segs,
                               {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100});
        end
        n_tests++;
        if (pf !== 1'b0 || dpn !== 4'hF) begin n_fail++; $display("FAIL mid_frame_pend_dp: got %b %b want 0 1111", pf, dpn); end
    endtask

    task automatic test_last_wins();
        logic [27:0] segs; logic [3:0] dpn, anok; logic ok, pf;
        step(4);
        pulse_load(16'hAAAA, 4'b0000);
        step(2);
        pulse_load(16'hC0DE, 4'b0000);
        capture_frame(segs, dpn, anok, ok, pf);
        n_tests++;
        if (!ok || segs !== {7'b0110001, 7'b0000001, 7'b0000001, 7'b0110000}) begin
            n_fail++; $display("FAIL last_wins_seg: got ok %b segs %h want %h", ok, segs,
                               {7'b0110001, 7'b0000001, 7'b0000001, 7'b0110000});
        end
    endtask

    task automatic test_load_at_commit();
        logic [27:0] segs; logic [3:0] dpn, anok; logic ok, pf;
        step(4);
        pulse_load(16'h5678, 4'b0000);
        step(12);
        pulse_load(16'h4321, 4'b0000);
        n_tests++;
        if (frame_start !== 1'b1 || pending !== 1'b1) begin
            n_fail++; $display("FAIL commit_coincide: got fs %b pending %b want 1 1", frame_start, pending);
        end
        capture_frame(segs, dpn, anok, ok, pf);
        n_tests++;
        if (!ok || pf !== 1'b1 || segs !== {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000}) begin
            n_fail++; $display("FAIL commit_old_frame: got ok %b pend %b segs %h want 1 1 %h", ok, pf, segs,
                               {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000});
        end
        capture_frame(segs, dpn, anok, ok, pf);
        n_tests++;
        if (!ok || pf !== 1'b0 || segs !== {7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111}) begin
            n_fail++; $display("FAIL commit_new_frame: got ok %b pend %b segs %h want 1 0 %h", ok, pf, segs,
                               {7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111});
        end
    endtask

    task automatic test_glyphs();
        logic [27:0] segs, exp_segs; logic [3:0] dpn, anok; logic ok, pf;
        logic [15:0] codes;
        for (int g = 0; g < 4; g++) begin
            codes    = 16'(((4*g+3) << 12) | ((4*g+2) << 8) | ((4*g+1) << 4) | (4*g));
            exp_segs = {glyph_tab[4*g+3], glyph_tab[4*g+2], glyph_tab[4*g+1], glyph_tab[4*g]};
            step(4);
            pulse_load(codes, 4'b0000);
            capture_frame(segs, dpn, anok, ok, pf);
            n_tests++;
            if (!ok || segs !== exp_segs) begin
                n_fail++; $display("FAIL glyph_set%0d: got ok %b segs %h want %h", g, ok, segs, exp_segs);
            end
        end
    endtask

    task automatic test_dp_lzb();
        logic [27:0] segs, exp_segs; logic [3:0] dpn, anok; logic ok, pf;
`ifdef LEADING_ZERO_BLANK_EN
        exp_segs = {7'b1111111, 7'b1111111, 7'b1111111, 7'b0100100};
`else
        exp_segs = {7'b0000001, 7'b0000001, 7'b0000001, 7'b0100100};
`endif
        step(4);
        pulse_load(16'h0005, 4'b0010);
        capture_frame(segs, dpn, anok, ok, pf);
        n_tests++;
        if (!ok || dpn !== 4'b1101) begin n_fail++; $display("FAIL dp_digit1: got ok %b dp_n %b want 1 1101", ok, dpn); end
        n_tests++;
        if (segs !== exp_segs) begin n_fail++; $display("FAIL lzb_seg: got %h want %h", segs, exp_segs); end
    endtask

    task automatic test_reset_midslot();
        logic [27:0] segs; logic [3:0] dpn, anok; logic ok, pf;
        step(4);
        pulse_load(16'h1111, 4'b1111);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check_reset_outputs("midrst");
        check_scan_restart("midrst");
        capture_frame(segs, dpn, anok, ok, pf);
        n_tests++;
        if (!ok || pf !== 1'b0 || segs !== {4{7'b1111111}} || dpn !== 4'hF) begin
            n_fail++; $display("FAIL midrst_discard: got ok %b pend %b segs %h dp_n %b want 1 0 fffffff 1111",
                               ok, pf, segs, dpn);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        load   = 1'b0;
        digits = 16'h0000;
        dp     = 4'h0;
        test_reset();
        test_load_midframe();
        test_last_wins();
        test_load_at_commit();
        test_glyphs();
        test_dp_lzb();
        test_reset_midslot();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
